hc_stream_xor: RTL and testbench

HC_STREAM_XOR -- requirements
Module: hc_stream_xor

---
 rtl/hc_pkg.sv | 20 ++
 rtl/hc_ks_fifo.sv | 58 +++++
 rtl/hc_stream_xor.sv | 127 ++++++++++++
 tb/tb_hc_stream_xor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// Shared types and constants for the keystream XOR stream block.
package hc_pkg;

  localparam int unsigned HC_WORD_W    = 32;
  localparam int unsigned HC_DEPTH_MIN = 2;
  localparam int unsigned HC_DEPTH_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } hc_state_e;

  // DEPTH must be a power of two inside the supported range.
  function automatic bit hc_depth_legal(input int unsigned depth);
    return (depth >= HC_DEPTH_MIN) && (depth <= HC_DEPTH_MAX) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/hc_ks_fifo.sv
// Keystream word FIFO: power-of-two depth, pointers wrap naturally,
// synchronous clear has priority over push and pop.
module hc_ks_fifo
  import hc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [HC_WORD_W-1:0]     wdata,
  input  logic                     pop,
  output logic [HC_WORD_W-1:0]     head,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [HC_WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  assign head = mem[rd_ptr];

  // Storage carries no reset; only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/hc_stream_xor.sv
// Stream cipher XOR stage: prefetches keystream words into a FIFO and XORs
// them onto the data stream. HC_STREAM_XOR_WORD_CTR_EN adds a 64-bit output word counter.
module hc_stream_xor
  import hc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   flush,
  output logic                   ks_next,
  input  logic [HC_WORD_W-1:0]   ks_word,
  input  logic                   ks_valid,
  input  logic [HC_WORD_W-1:0]   din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [HC_WORD_W-1:0]   dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [$clog2(DEPTH):0] fill
`ifdef HC_STREAM_XOR_WORD_CTR_EN
  ,
  output logic [63:0]            word_ctr
`endif
);

  localparam int unsigned FILL_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W  = FILL_W + 1;

  if (!hc_depth_legal(DEPTH)) begin : g_bad_depth
    $error("hc_stream_xor: DEPTH must be a power of two in [2,16]");
  end

  hc_state_e            state;
  logic                 discard;
  logic                 pending;
  logic                 room;
  logic                 push;
  logic                 accept;
  logic [HC_WORD_W-1:0] head;

  // A live request already owns a FIFO slot; a discarded one does not.
  assign pending = (state != IDLE) && !discard;
  assign room    = (SUM_W'(fill) + SUM_W'(pending)) < SUM_W'(DEPTH);

  assign push      = (state == WAIT) && ks_valid && !discard && !flush;
  assign din_ready = (fill != '0) && (!dout_valid || dout_ready) && !flush;
  assign accept    = din_valid && din_ready;

  hc_ks_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (push),
    .wdata   (ks_word),
    .pop     (accept),
    .head    (head),
    .fill    (fill)
  );

  // Prefetch FSM; ks_next is high exactly while in REQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ks_next <= 1'b0;
      discard <= 1'b0;
    end else begin
      ks_next <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !flush && room) begin
            state   <= REQ;
            ks_next <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
          if (flush) begin
            discard <= 1'b1;
          end
        end
        WAIT: begin
          if (ks_valid) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output register: holds under backpressure, flush wins over a handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      dout_valid <= 1'b0;
    end else if (accept) begin
      dout       <= din ^ head;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

`ifdef HC_STREAM_XOR_WORD_CTR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_ctr <= '0;
    end else if (flush) begin
      word_ctr <= '0;
    end else if (dout_valid && dout_ready) begin
      word_ctr <= word_ctr + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hc_stream_xor.sv
// Scoreboard bench for hc_stream_xor: directed stimulus, queued expectations,
// independent output monitor and a keystream core model answering after 3 cycles.
module tb_hc_stream_xor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        flush;
  logic        ks_next;
  logic [31:0] ks_word;
  logic        ks_valid;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [2:0]  fill;
`ifdef HC_STREAM_XOR_WORD_CTR_EN
  logic [63:0] word_ctr;
`endif

  logic        core_valid  = 1'b0;
  logic [31:0] core_word   = '0;
  logic        stray_valid = 1'b0;

  int          compared   = 0;
  int          mismatched = 0;
  int          ks_pulses  = 0;
  int          core_cnt   = 0;
  logic [31:0] ks_words[$];
  logic [31:0] sb[$];

  assign ks_valid = core_valid | stray_valid;
  assign ks_word  = stray_valid ? 32'h5555_5555 : core_word;

  always #5 clk = ~clk;

  hc_stream_xor #(
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .flush      (flush),
    .ks_next    (ks_next),
    .ks_word    (ks_word),
    .ks_valid   (ks_valid),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fill       (fill)
`ifdef HC_STREAM_XOR_WORD_CTR_EN
    ,
    .word_ctr   (word_ctr)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Keystream core: answers each ks_next with one ks_valid 3 cycles later.
  always @(negedge clk) begin
    core_valid = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_valid = 1'b1;
        if (ks_words.size() > 0) core_word = ks_words.pop_front();
        else                     core_word = 32'h0;
      end
    end
    if (ks_next === 1'b1) begin
      core_cnt = 3;
      ks_pulses++;
    end
  end

  // Output monitor: every dout handshake is matched against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (reset_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL dout_unexpected: actual=%h required=none", dout);
      end else begin
        exp = sb.pop_front();
        check("dout", 64'(dout), 64'(exp));
      end
    end
  end

  // Offers one word; returns just after the accepting edge.
  task automatic send(input logic [31:0] d);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    din       = d;
    din_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (din_ready === 1'b1) ok = 1'b1;
      n++;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: actual=no_accept required=accept of %h", d);
    end
  endtask

  task automatic wait_ks_next(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (ks_next === 1'b1) found = 1'b1;
    end
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int p0;

    reset_n = 1'b0; enable = 1'b0; flush = 1'b0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ks_next", 64'(ks_next), 64'(0));
    check("rst_fill", 64'(fill), 64'(0));
    check("rst_dout_valid", 64'(dout_valid), 64'(0));
    check("rst_dout", 64'(dout), 64'(0));
    check("rst_din_ready", 64'(din_ready), 64'(0));

    // Prefetch fills exactly DEPTH words, then stops requesting
    ks_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    @(posedge clk); #1;
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (40) @(negedge clk);
    check("prefetch_pulses", 64'(ks_pulses), 64'(4));
    check("prefetch_fill", 64'(fill), 64'(4));
    repeat (20) @(negedge clk);
    check("prefetch_no_more", 64'(ks_pulses), 64'(4));
    @(posedge clk); #1;
    enable = 1'b0;

    // Encryption, back to back
    dout_ready = 1'b1;
    sb.push_back(32'hBBBB_BBBB);
    sb.push_back(32'h8888_8888);
    sb.push_back(32'h9999_9999);
    sb.push_back(32'hEEEE_EEEE);
    for (int i = 0; i < 4; i++) send(32'hAAAA_AAAA);
    repeat (3) @(negedge clk);
    check("enc_fill", 64'(fill), 64'(0));
    check("enc_valid_clear", 64'(dout_valid), 64'(0));

    // Backpressure
    ks_words = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
    @(posedge clk); #1;
    enable = 1'b1;
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    check("bp_prefill", 64'(fill), 64'(4));
    @(posedge clk); #1;
    dout_ready = 1'b0;
    sb.push_back(32'h0E0D_0C0B);
    sb.push_back(32'h1732_5170);
    send(32'h0F0F_0F0F);
    din       = 32'h1234_5678;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_dout", 64'(dout), 64'(32'h0E0D_0C0B));
      check("bp_dout_valid", 64'(dout_valid), 64'(1));
      check("bp_din_ready", 64'(din_ready), 64'(0));
      check("bp_fill", 64'(fill), 64'(3));
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    send(32'h1234_5678);
    repeat (3) @(negedge clk);
    check("bp_fill_after", 64'(fill), 64'(2));
    check("bp_valid_clear", 64'(dout_valid), 64'(0));

    // Flush during WAIT drops the in-flight word
    ks_words = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    @(posedge clk); #1;
    enable = 1'b1;
    wait_ks_next(found);
    check("fl_req_seen", 64'(found), 64'(1));
    pulse_flush();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fl_fill_zero", 64'(fill), 64'(0));
    end
    p0 = ks_pulses;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (ks_pulses > p0) found = 1'b1;
    end
    check("fl_next_req", 64'(found), 64'(1));
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (8) @(negedge clk);
    check("fl_refill", 64'(fill), 64'(1));
    @(posedge clk); #1;
    sb.push_back(32'hCAFE_F00D);
    send(32'h0000_0000);
    repeat (3) @(negedge clk);
    check("fl_drained", 64'(fill), 64'(0));

    // Stray ks_valid while idle with enable low
    @(posedge clk); #1;
    p0 = ks_pulses;
    stray_valid = 1'b1;
    @(posedge clk); #1;
    stray_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_fill", 64'(fill), 64'(0));
    check("stray_no_req", 64'(ks_pulses), 64'(p0));

    // Reset while WAITing abandons the request
    ks_words = '{32'h7777_7777};
    @(posedge clk); #1;
    enable = 1'b1;
    wait_ks_next(found);
    check("rw_req_seen", 64'(found), 64'(1));
    @(posedge clk); #1;
    enable  = 1'b0;
    reset_n = 1'b0;
    p0 = ks_pulses;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rw_fill", 64'(fill), 64'(0));
    check("rw_no_req", 64'(ks_pulses), 64'(p0));
    check("rw_din_ready", 64'(din_ready), 64'(0));

    // Longer stream with concurrent prefetch, then counter and flush
    pulse_flush();
    ks_words.delete();
    for (int i = 0; i < 10; i++) ks_words.push_back(32'hA000_0000 + 32'(i));
    enable     = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sb.push_back((32'hA000_0000 + 32'(i)) ^ 32'h0000_FFFF);
      send(32'h0000_FFFF);
    end
    enable = 1'b0;
    repeat (10) @(negedge clk);
`ifdef HC_STREAM_XOR_WORD_CTR_EN
    check("ctr_after_10", word_ctr, 64'd10);
`endif
    pulse_flush();
    @(negedge clk);
    check("end_flush_fill", 64'(fill), 64'(0));
`ifdef HC_STREAM_XOR_WORD_CTR_EN
    check("ctr_after_flush", word_ctr, 64'd0);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
